uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters sharing the UART transmit path (2..8).
REQ-002 SHALL have parameter DATA_W, default 8: byte width written to the UART core.
REQ-003 SHALL have port clk_100MHz  input  1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-005 SHALL have port req  input  N_REQ: per-requester "byte pending" level.
REQ-006 SHALL have port req_data  input  N_REQ*DATA_W: flattened bytes; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-007 SHALL have port req_last  input  N_REQ: marks the presented byte as last of a packet; used only under UART_ARB_LOCK_EN.
REQ-008 SHALL have port tx_full  input  1: UART core transmit FIFO full flag.
REQ-009 SHALL have port ack  output  N_REQ: one-hot, one-cycle pulse; the byte of that requester was written.
REQ-010 SHALL have port write_uart  output  1: one-cycle write strobe to the UART core.
REQ-011 SHALL have port write_data  output  DATA_W: byte to the UART core, valid while write_uart=1.
REQ-012 SHALL have port owner  output  $clog2(N_REQ): index of the current grant holder.
REQ-013 SHALL have port busy  output  1: high when state is not IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, XFER, WAIT.
REQ-015 In IDLE with |req=1, SHALL register owner = first requester with req high, searching circularly from rr_ptr+1, and go to XFER; with req=0, SHALL stay in IDLE.
REQ-016 In XFER with req[owner]=0 (withdrawn), SHALL return to IDLE without writing.
REQ-017 In XFER with req[owner]=1 and tx_full=1, SHALL hold XFER with no write and no ack.
REQ-018 In XFER with req[owner]=1 and tx_full=0, SHALL register write_uart=1, write_data=req_data[owner], and ack=onehot(owner), all high exactly one cycle, then go to WAIT.
REQ-019 WAIT SHALL last exactly one cycle so that tx_full reflects the write just made; no write occurs in WAIT.
REQ-020 On leaving WAIT without lock, SHALL set rr_ptr=owner and go to IDLE.
REQ-021 Latency from req rising in IDLE (tx_full=0) to write_uart SHALL be 2 cycles; maximum rate is 1 byte per 3 cycles unlocked and 1 byte per 2 cycles locked.
REQ-022 Requesters SHALL hold req_data stable from req rising until ack; a requester may drop req or present the next byte in the ack cycle.
REQ-023 Round-robin SHALL guarantee that a continuously requesting requester is served within N_REQ grants.
REQ-024 Simultaneous requests from all requesters after reset (rr_ptr=N_REQ-1) SHALL be granted in order 0,1,2,...
REQ-025 ack and write_uart SHALL never assert in the same cycle as tx_full=1 being sampled in XFER.

Reset
REQ-026 Reset SHALL force state=IDLE, rr_ptr=N_REQ-1, owner=0, ack=0, write_uart=0, write_data=0, busy=0, asynchronously.
REQ-027 Reset mid-transfer SHALL drop any pending write; no ack is issued for that byte.

Configuration
REQ-028 With UART_ARB_LOCK_EN defined, after WAIT SHALL return to XFER with the same owner while the written byte had req_last[owner]=0; a byte with req_last=1 releases to IDLE with rr_ptr=owner.
REQ-029 With UART_ARB_LOCK_EN defined, withdrawal in XFER (REQ-016) SHALL also release the lock.
REQ-030 Without UART_ARB_LOCK_EN, req_last SHALL be ignored and every byte re-arbitrates.

Structure
REQ-031 Package uart_pkg SHALL hold the FSM state typedef (IDLE/XFER/WAIT) and the default N_REQ and DATA_W constants.
REQ-032 The circular priority search SHALL be a sub-module uart_rr_picker (inputs req, rr_ptr; outputs found and index).

Verification
REQ-033 Single request: req=4'b0100, req_data[23:16]=8'h41, tx_full=0 -> write_uart 2 cycles later with write_data=8'h41, ack=4'b0100, one pulse.
REQ-034 Fairness: req=4'b1111 held, bytes 8'h30..8'h33 -> writes in order 0,1,2,3,0,..., 3 cycles apart (lock off).
REQ-035 Backpressure: tx_full=1 for 10 cycles while owner=1 in XFER -> no write_uart/ack; write 1 cycle after tx_full falls.
REQ-036 Withdrawal: req[2] dropped while in XFER -> return to IDLE, no ack, next requester granted.
REQ-037 Lock (UART_ARB_LOCK_EN): requester 3 sends 3 bytes with req_last=0,0,1 while req[0]=1 -> three consecutive writes from 3 (2 cycles apart), then grant to 0.
REQ-038 Reset asserted in WAIT -> all outputs 0 asynchronously; first grant after release goes to requester 0.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit arbiter:
//   - uart_state_t        : arbiter FSM states (IDLE / XFER / WAIT)
//   - UART_N_REQ_DEF      : default number of requesters
//   - UART_DATA_W_DEF     : default byte width written to the UART core
// -----------------------------------------------------------------------------
package uart_pkg;

   localparam int UART_N_REQ_DEF  = 4;
   localparam int UART_DATA_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      WAIT = 2'd2
   } uart_state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter_if
// Bundle of the requester-side and UART-core-side signals of uart_tx_arbiter.
//   master : requesters + UART core model (drive req/req_data/req_last/tx_full)
//   slave  : the arbiter (drives ack/write_uart/write_data/owner/busy)
// Parameters N_REQ / DATA_W must match the arbiter instance.
// -----------------------------------------------------------------------------
interface uart_tx_arbiter_if
   import uart_pkg::*;
#(
   parameter int N_REQ  = UART_N_REQ_DEF,
   parameter int DATA_W = UART_DATA_W_DEF
);

   logic [N_REQ-1:0]         req;
   logic [N_REQ*DATA_W-1:0]  req_data;
   logic [N_REQ-1:0]         req_last;
   logic                     tx_full;
   logic [N_REQ-1:0]         ack;
   logic                     write_uart;
   logic [DATA_W-1:0]        write_data;
   logic [$clog2(N_REQ)-1:0] owner;
   logic                     busy;

   modport master (
      output req, req_data, req_last, tx_full,
      input  ack, write_uart, write_data, owner, busy
   );

   modport slave (
      input  req, req_data, req_last, tx_full,
      output ack, write_uart, write_data, owner, busy
   );

endinterface

// File: rtl/uart_rr_picker.sv
// -----------------------------------------------------------------------------
// uart_rr_picker
// Circular priority search: returns the first asserted bit of req, starting
// at rr_ptr+1 and wrapping, so the last-served requester has lowest priority.
// Ports:
//   req    in  N_REQ  : request levels
//   rr_ptr in  IDX_W  : index of the requester served last
//   found  out 1      : at least one request is pending
//   index  out IDX_W  : winning requester (0 when found=0)
// -----------------------------------------------------------------------------
module uart_rr_picker #(
   parameter  int N_REQ = 4,
   localparam int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] rr_ptr,
   output logic             found,
   output logic [IDX_W-1:0] index
);

   int               cand;
   logic [IDX_W-1:0] cand_idx;

   // Walk from the farthest candidate back to the nearest one so that the
   // closest requester after rr_ptr is the final (winning) assignment.
   always_comb begin
      found    = 1'b0;
      index    = '0;
      cand     = 0;
      cand_idx = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         cand     = (int'(rr_ptr) + k) % N_REQ;
         cand_idx = IDX_W'(cand);
         if (req[cand_idx]) begin
            found = 1'b1;
            index = cand_idx;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Round-robin arbiter sharing one UART transmit path among N_REQ requesters.
// Each granted byte is written with a one-cycle write_uart strobe and a
// one-hot ack to the owner, followed by one WAIT cycle so tx_full reflects
// the write before the next decision.
//
// Optional feature (macro UART_ARB_LOCK_EN): the grant stays with the owner
// across bytes until a byte marked req_last=1 is written (or the owner
// withdraws). Without the macro req_last is ignored.
//
// Ports:
//   clk_100MHz in  1            : clock, rising edge
//   reset      in  1            : asynchronous active-high reset
//   req        in  N_REQ        : per-requester byte-pending level
//   req_data   in  N_REQ*DATA_W : requester i at [i*DATA_W +: DATA_W]
//   req_last   in  N_REQ        : last byte of packet (lock build only)
//   tx_full    in  1            : UART core TX FIFO full
//   ack        out N_REQ        : one-hot pulse, owner's byte was written
//   write_uart out 1            : write strobe to UART core
//   write_data out DATA_W       : byte to UART core
//   owner      out $clog2(N_REQ): current grant holder
//   busy       out 1            : FSM not in IDLE
// -----------------------------------------------------------------------------
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int N_REQ  = UART_N_REQ_DEF,
   parameter int DATA_W = UART_DATA_W_DEF
) (
   input  logic                     clk_100MHz,
   input  logic                     reset,
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ*DATA_W-1:0]  req_data,
   input  logic [N_REQ-1:0]         req_last,
   input  logic                     tx_full,
   output logic [N_REQ-1:0]         ack,
   output logic                     write_uart,
   output logic [DATA_W-1:0]        write_data,
   output logic [$clog2(N_REQ)-1:0] owner,
   output logic                     busy
);

   localparam int IDX_W = $clog2(N_REQ);

   uart_state_t      state_q,      state_d;
   logic [IDX_W-1:0] owner_q,      owner_d;
   logic [IDX_W-1:0] rr_ptr_q,     rr_ptr_d;
   logic             write_uart_q, write_uart_d;
   logic [DATA_W-1:0] write_data_q, write_data_d;
   logic [N_REQ-1:0] ack_q,        ack_d;

   logic             pick_found;
   logic [IDX_W-1:0] pick_index;

`ifdef UART_ARB_LOCK_EN
   // req_last of the byte just written, decides lock hold vs release in WAIT
   logic             last_q, last_d;
`else
   // req_last has no meaning when every byte re-arbitrates
   logic             unused_req_last;
   assign unused_req_last = ^req_last;
`endif

   uart_rr_picker #(
      .N_REQ (N_REQ)
   ) u_picker (
      .req    (req),
      .rr_ptr (rr_ptr_q),
      .found  (pick_found),
      .index  (pick_index)
   );

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      rr_ptr_d     = rr_ptr_q;
      write_uart_d = 1'b0;
      write_data_d = write_data_q;
      ack_d        = '0;
`ifdef UART_ARB_LOCK_EN
      last_d       = last_q;
`endif
      case (state_q)
         IDLE: begin
            if (pick_found) begin
               owner_d = pick_index;
               state_d = XFER;
            end
         end
         XFER: begin
            // A withdrawn owner forfeits the grant (and any lock)
            if (!req[owner_q]) begin
               state_d = IDLE;
            end else if (!tx_full) begin
               write_uart_d   = 1'b1;
               write_data_d   = req_data[int'(owner_q)*DATA_W +: DATA_W];
               ack_d[owner_q] = 1'b1;
               state_d        = WAIT;
`ifdef UART_ARB_LOCK_EN
               last_d         = req_last[owner_q];
`endif
            end
         end
         WAIT: begin
`ifdef UART_ARB_LOCK_EN
            if (last_q) begin
               rr_ptr_d = owner_q;
               state_d  = IDLE;
            end else begin
               state_d  = XFER;
            end
`else
            rr_ptr_d = owner_q;
            state_d  = IDLE;
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         owner_q      <= '0;
         rr_ptr_q     <= IDX_W'(N_REQ - 1);
         write_uart_q <= 1'b0;
         write_data_q <= '0;
         ack_q        <= '0;
`ifdef UART_ARB_LOCK_EN
         last_q       <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         rr_ptr_q     <= rr_ptr_d;
         write_uart_q <= write_uart_d;
         write_data_q <= write_data_d;
         ack_q        <= ack_d;
`ifdef UART_ARB_LOCK_EN
         last_q       <= last_d;
`endif
      end
   end

   assign ack        = ack_q;
   assign write_uart = write_uart_q;
   assign write_data = write_data_q;
   assign owner      = owner_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Self-checking bench for uart_tx_arbiter (N_REQ=4, DATA_W=8). Expected
// writes are pushed to a scoreboard queue when requests are loaded and popped
// when write_uart is observed. Lock scenarios follow UART_ARB_LOCK_EN.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

   localparam int N = 4;
   localparam int W = 8;

   typedef struct {
      int         idx;
      logic [7:0] data;
      int         gap;   // cycles from previous write (or from stimulus)
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   uart_tx_arbiter_if #(.N_REQ(N), .DATA_W(W)) bus ();

   uart_tx_arbiter #(
      .N_REQ  (N),
      .DATA_W (W)
   ) dut (
      .clk_100MHz (clk),
      .reset      (rst),
      .req        (bus.req),
      .req_data   (bus.req_data),
      .req_last   (bus.req_last),
      .tx_full    (bus.tx_full),
      .ack        (bus.ack),
      .write_uart (bus.write_uart),
      .write_data (bus.write_data),
      .owner      (bus.owner),
      .busy       (bus.busy)
   );

   exp_t       sb [$];
   logic [8:0] rq [N][$];   // {last, data} per requester
   bit         auto_mode;
   int         passed = 0;
   int         total  = 0;

   // Present the head of every requester queue (req drops when empty)
   task automatic drive_reqs();
      logic [N-1:0]   r;
      logic [N*W-1:0] d;
      logic [N-1:0]   l;
      r = '0;
      d = bus.req_data;
      l = bus.req_last;
      for (int i = 0; i < N; i++) begin
         if (rq[i].size() > 0) begin
            r[i]         = 1'b1;
            d[i*W +: W]  = rq[i][0][7:0];
            l[i]         = rq[i][0][8];
         end
      end
      bus.req      = r;
      bus.req_data = d;
      bus.req_last = l;
   endtask

   // Advance to the next falling edge; in auto mode requesters react to ack
   task automatic step();
      @(negedge clk);
      if (auto_mode) begin
         for (int i = 0; i < N; i++)
            if (bus.ack[i] === 1'b1 && rq[i].size() > 0)
               void'(rq[i].pop_front());
         drive_reqs();
      end
   endtask

   task automatic wait_write(input int budget, output int cycles, output bit seen);
      seen   = 1'b0;
      cycles = 0;
      while (!seen && cycles < budget) begin
         step();
         cycles++;
         if (bus.write_uart === 1'b1) seen = 1'b1;
      end
   endtask

   task automatic apply_reset();
      rst          = 1'b1;
      auto_mode    = 1'b0;
      bus.req      = '0;
      bus.req_data = '0;
      bus.req_last = '0;
      bus.tx_full  = 1'b0;
      for (int i = 0; i < N; i++) rq[i].delete();
      sb.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      bus.req      = '0;
      bus.req_data = '0;
      bus.req_last = '0;
      bus.tx_full  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      total++; if (bus.write_uart !== 1'b0) $display("FAIL reset_write: got %0b want 0", bus.write_uart); else passed++;
      total++; if (bus.ack !== 4'b0000) $display("FAIL reset_ack: got %b want 0000", bus.ack); else passed++;
      total++; if (bus.write_data !== 8'h00) $display("FAIL reset_data: got %0h want 00", bus.write_data); else passed++;
      total++; if (bus.owner !== 2'd0) $display("FAIL reset_owner: got %0d want 0", bus.owner); else passed++;
      total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", bus.busy); else passed++;
      rst = 1'b0;
   endtask

   task automatic test_single();
      exp_t e;
      int   c;
      bit   seen;
      apply_reset();
      auto_mode = 1'b1;
      rq[2].push_back({1'b0, 8'h41});
      sb.push_back('{idx: 2, data: 8'h41, gap: 2});
      drive_reqs();
      wait_write(10, c, seen);
      total++; if (!seen) $display("FAIL single_seen: got no write want write"); else passed++;
      if (seen) begin
         e = sb.pop_front();
         total++; if (c !== e.gap) $display("FAIL single_latency: got %0d want %0d", c, e.gap); else passed++;
         total++; if (bus.ack !== (4'b0001 << e.idx)) $display("FAIL single_ack: got %b want %b", bus.ack, 4'b0001 << e.idx); else passed++;
         total++; if (bus.write_data !== e.data) $display("FAIL single_data: got %0h want %0h", bus.write_data, e.data); else passed++;
      end
      step();
      total++; if (bus.write_uart !== 1'b0 || bus.ack !== 4'b0000)
         $display("FAIL single_pulse: got write=%0b ack=%b want 0/0000", bus.write_uart, bus.ack); else passed++;
   endtask

   task automatic test_fairness();
      exp_t e;
      int   c;
      bit   seen;
      apply_reset();
      auto_mode = 1'b1;
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < N; i++) begin
            rq[i].push_back({1'b0, 8'(8'h30 + i)});
            sb.push_back('{idx: i, data: 8'(8'h30 + i), gap: (r == 0 && i == 0) ? 2 : 3});
         end
      drive_reqs();
      for (int n = 0; n < 2 * N; n++) begin
         wait_write(12, c, seen);
         total++; if (!seen) $display("FAIL fair_seen[%0d]: got no write want write", n); else passed++;
         if (!seen) break;
         e = sb.pop_front();
         total++; if (bus.ack !== (4'b0001 << e.idx)) $display("FAIL fair_ack[%0d]: got %b want %b", n, bus.ack, 4'b0001 << e.idx); else passed++;
         total++; if (bus.write_data !== e.data) $display("FAIL fair_data[%0d]: got %0h want %0h", n, bus.write_data, e.data); else passed++;
         total++; if (c !== e.gap) $display("FAIL fair_gap[%0d]: got %0d want %0d", n, c, e.gap); else passed++;
      end
   endtask

   task automatic test_backpressure();
      exp_t e;
      int   c;
      bit   seen;
      int   bad;
      apply_reset();
      auto_mode   = 1'b1;
      bus.tx_full = 1'b1;
      rq[1].push_back({1'b0, 8'h55});
      sb.push_back('{idx: 1, data: 8'h55, gap: 1});
      drive_reqs();
      step();
      total++; if (bus.owner !== 2'd1 || bus.busy !== 1'b1)
         $display("FAIL bp_grant: got owner=%0d busy=%0b want 1/1", bus.owner, bus.busy); else passed++;
      bad = 0;
      for (int k = 0; k < 10; k++) begin
         step();
         if (bus.write_uart !== 1'b0 || bus.ack !== 4'b0000) bad++;
      end
      total++; if (bad !== 0) $display("FAIL bp_hold: got %0d write/ack cycles want 0", bad); else passed++;
      bus.tx_full = 1'b0;
      wait_write(5, c, seen);
      total++; if (!seen) $display("FAIL bp_seen: got no write want write"); else passed++;
      if (seen) begin
         e = sb.pop_front();
         total++; if (c !== e.gap) $display("FAIL bp_latency: got %0d want %0d", c, e.gap); else passed++;
         total++; if (bus.ack !== (4'b0001 << e.idx) || bus.write_data !== e.data)
            $display("FAIL bp_write: got ack=%b data=%0h want %b/%0h", bus.ack, bus.write_data, 4'b0001 << e.idx, e.data); else passed++;
      end
   endtask

   task automatic test_withdrawal();
      exp_t e;
      int   c;
      bit   seen;
      apply_reset();
      bus.tx_full          = 1'b1;
      bus.req_data[23:16]  = 8'h66;
      bus.req              = 4'b0100;
      step();
      total++; if (bus.owner !== 2'd2) $display("FAIL wd_owner: got %0d want 2", bus.owner); else passed++;
      step();
      bus.req             = 4'b1000;
      bus.req_data[31:24] = 8'h77;
      bus.tx_full         = 1'b0;
      sb.push_back('{idx: 3, data: 8'h77, gap: 2});
      step();
      total++; if (bus.busy !== 1'b0 || bus.write_uart !== 1'b0 || bus.ack !== 4'b0000)
         $display("FAIL wd_idle: got busy=%0b write=%0b ack=%b want 0/0/0000", bus.busy, bus.write_uart, bus.ack); else passed++;
      wait_write(6, c, seen);
      total++; if (!seen) $display("FAIL wd_seen: got no write want write"); else passed++;
      if (seen) begin
         e = sb.pop_front();
         total++; if (c !== e.gap) $display("FAIL wd_latency: got %0d want %0d", c, e.gap); else passed++;
         total++; if (bus.ack !== (4'b0001 << e.idx) || bus.write_data !== e.data)
            $display("FAIL wd_write: got ack=%b data=%0h want %b/%0h", bus.ack, bus.write_data, 4'b0001 << e.idx, e.data); else passed++;
      end
      bus.req = 4'b0000;
      step();
   endtask

   task automatic test_lock();
      exp_t e;
      int   c;
      bit   seen;
      apply_reset();
      auto_mode = 1'b1;
      rq[3].push_back({1'b0, 8'hA0});
      rq[3].push_back({1'b0, 8'hA1});
      rq[3].push_back({1'b1, 8'hA2});
      drive_reqs();
      step();
      rq[0].push_back({1'b1, 8'h10});
      drive_reqs();
`ifdef UART_ARB_LOCK_EN
      sb.push_back('{idx: 3, data: 8'hA0, gap: 1});
      sb.push_back('{idx: 3, data: 8'hA1, gap: 2});
      sb.push_back('{idx: 3, data: 8'hA2, gap: 2});
      sb.push_back('{idx: 0, data: 8'h10, gap: 3});
`else
      sb.push_back('{idx: 3, data: 8'hA0, gap: 1});
      sb.push_back('{idx: 0, data: 8'h10, gap: 3});
      sb.push_back('{idx: 3, data: 8'hA1, gap: 3});
      sb.push_back('{idx: 3, data: 8'hA2, gap: 3});
`endif
      for (int n = 0; n < 4; n++) begin
         wait_write(10, c, seen);
         total++; if (!seen) $display("FAIL lock_seen[%0d]: got no write want write", n); else passed++;
         if (!seen) break;
         e = sb.pop_front();
         total++; if (bus.ack !== (4'b0001 << e.idx)) $display("FAIL lock_ack[%0d]: got %b want %b", n, bus.ack, 4'b0001 << e.idx); else passed++;
         total++; if (bus.write_data !== e.data) $display("FAIL lock_data[%0d]: got %0h want %0h", n, bus.write_data, e.data); else passed++;
         total++; if (c !== e.gap) $display("FAIL lock_gap[%0d]: got %0d want %0d", n, c, e.gap); else passed++;
      end
   endtask

   task automatic test_reset_in_wait();
      exp_t e;
      int   c;
      bit   seen;
      apply_reset();
      bus.req_data[23:16] = 8'h5A;
      bus.req             = 4'b0100;
      wait_write(5, c, seen);
      total++; if (!seen) $display("FAIL rw_reach_wait: got no write want write"); else passed++;
      #1 rst = 1'b1;
      #1;
      total++; if (bus.write_uart !== 1'b0 || bus.ack !== 4'b0000 || bus.busy !== 1'b0)
         $display("FAIL rw_async: got write=%0b ack=%b busy=%0b want 0/0000/0", bus.write_uart, bus.ack, bus.busy); else passed++;
      total++; if (bus.owner !== 2'd0 || bus.write_data !== 8'h00)
         $display("FAIL rw_async_regs: got owner=%0d data=%0h want 0/00", bus.owner, bus.write_data); else passed++;
      bus.req_data[7:0] = 8'h11;
      bus.req           = 4'b0111;
      step();
      rst = 1'b0;
      sb.push_back('{idx: 0, data: 8'h11, gap: 2});
      wait_write(6, c, seen);
      total++; if (!seen) $display("FAIL rw_seen: got no write want write"); else passed++;
      if (seen) begin
         e = sb.pop_front();
         total++; if (bus.ack !== (4'b0001 << e.idx) || bus.write_data !== e.data)
            $display("FAIL rw_first_grant: got ack=%b data=%0h want %b/%0h", bus.ack, bus.write_data, 4'b0001 << e.idx, e.data); else passed++;
         total++; if (c !== e.gap) $display("FAIL rw_latency: got %0d want %0d", c, e.gap); else passed++;
      end
      bus.req = 4'b0000;
      step();
   endtask

   initial begin
      auto_mode = 1'b0;
      test_reset();
      test_single();
      test_fairness();
      test_backpressure();
      test_withdrawal();
      test_lock();
      test_reset_in_wait();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
